// File: rtl/dot_op_sequencer_if.sv
// Request, AU operand and response signals shared by dot_op_sequencer and its neighbours.
// slave = the sequencer itself; master = requesters, AU and response consumer.
interface dot_op_sequencer_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_op;
  logic [5:0] req_op1;
  logic [5:0] req_op2;
  logic       au_op;
  logic [2:0] au_op1;
  logic [2:0] au_op2;
  logic [5:0] au_result;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [5:0] resp_result;
  logic       resp_err;
  logic       busy;

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, au_result, resp_ready,
    output req_ready, au_op, au_op1, au_op2, resp_valid, resp_id, resp_result, resp_err, busy
  );

  modport master (
    output req_valid, req_op, req_op1, req_op2, au_result, resp_ready,
    input  req_ready, au_op, au_op1, au_op2, resp_valid, resp_id, resp_result, resp_err, busy
  );
endinterface

// File: rtl/dot_op_sequencer.sv
// Time-shares one combinational 3-bit multiply/divide AU between two requesters.
// Optional: define DOT_SEQ_DIVZERO_EN to answer divide-by-zero with 6'h3F and resp_err=1.
module dot_op_sequencer #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned AU_LATENCY  = 0
) (
  input logic               clk,
  input logic               rst,
  dot_op_sequencer_if.slave bus
);
  localparam logic [2:0] LAT_LOAD = 3'(AU_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] wait_q;
  logic       rr_ptr_q;
  logic       id_q;
  logic [1:0] grant;
  logic       accept, win_id, div_zero, resp_fire;
  logic       sel_op;
  logic [2:0] sel_op1, sel_op2;
  logic       au_op_q;
  logic [2:0] au_op1_q, au_op2_q;
  logic       resp_valid_q, resp_id_q;
  logic [5:0] resp_result_q;

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    // Held low during reset so nothing is granted while the sequencer is being cleared.
    if (!rst && state_q == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept    = |grant;
  assign win_id    = grant[1];
  assign sel_op    = bus.req_op[win_id];
  assign sel_op1   = win_id ? bus.req_op1[5:3] : bus.req_op1[2:0];
  assign sel_op2   = win_id ? bus.req_op2[5:3] : bus.req_op2[2:0];
  assign resp_fire = resp_valid_q & bus.resp_ready;

`ifdef DOT_SEQ_DIVZERO_EN
  assign div_zero = sel_op & (sel_op2 == 3'd0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = div_zero ? RESP : ISSUE;
      ISSUE:   if (wait_q == 3'd0) state_d = RESP;
      RESP:    if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q        <= 3'd0;
      rr_ptr_q      <= 1'b0;
      id_q          <= 1'b0;
      au_op_q       <= 1'b0;
      au_op1_q      <= 3'd0;
      au_op2_q      <= 3'd0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 6'd0;
    end else begin
      if (accept) begin
        au_op_q  <= sel_op;
        au_op1_q <= sel_op1;
        au_op2_q <= sel_op2;
        id_q     <= win_id;
        wait_q   <= LAT_LOAD;
        if (div_zero) begin
          resp_valid_q  <= 1'b1;
          resp_id_q     <= win_id;
          resp_result_q <= 6'h3F;
        end
      end
      if (state_q == ISSUE) begin
        if (wait_q != 3'd0) begin
          wait_q <= wait_q - 3'd1;
        end else begin
          resp_valid_q  <= 1'b1;
          resp_id_q     <= id_q;
          resp_result_q <= bus.au_result;
        end
      end
      // resp_valid is only ever high in RESP, so a fire always ends the op.
      if (resp_fire) begin
        resp_valid_q <= 1'b0;
        if (ROUND_ROBIN) rr_ptr_q <= ~resp_id_q;
      end
    end
  end

`ifdef DOT_SEQ_DIVZERO_EN
  logic resp_err_q;

  // Only changes on accept, i.e. while resp_valid is low.
  always_ff @(posedge clk) begin
    if (rst)         resp_err_q <= 1'b0;
    else if (accept) resp_err_q <= div_zero;
  end

  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready   = grant;
  assign bus.au_op       = au_op_q;
  assign bus.au_op1      = au_op1_q;
  assign bus.au_op2      = au_op2_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_dot_op_sequencer.sv
// Bench for dot_op_sequencer: two instances (RR=1/LAT=0 and RR=0/LAT=3) share one stimulus,
// a timeline model predicts outputs each cycle, and literal checks pin results and latency.
module tb_dot_op_sequencer;
`ifdef DOT_SEQ_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_op = 2'b00;
  logic [5:0] req_op1 = 6'd0;
  logic [5:0] req_op2 = 6'd0;
  logic       resp_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] au_ref(input logic op, input logic [2:0] a, input logic [2:0] b);
    int p, q, r;
    if (!op) begin
      p = int'(a) * int'(b);
      return 6'(p);
    end
    if (b == 3'd0) return 6'd0;
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return {3'(q), 3'(r)};
  endfunction

  dot_op_sequencer_if bus0 ();
  dot_op_sequencer_if bus1 ();

  assign bus0.req_valid  = req_valid;
  assign bus0.req_op     = req_op;
  assign bus0.req_op1    = req_op1;
  assign bus0.req_op2    = req_op2;
  assign bus0.resp_ready = resp_ready;
  assign bus0.au_result  = au_ref(bus0.au_op, bus0.au_op1, bus0.au_op2);
  assign bus1.req_valid  = req_valid;
  assign bus1.req_op     = req_op;
  assign bus1.req_op1    = req_op1;
  assign bus1.req_op2    = req_op2;
  assign bus1.resp_ready = resp_ready;
  assign bus1.au_result  = au_ref(bus1.au_op, bus1.au_op1, bus1.au_op2);

  dot_op_sequencer #(.ROUND_ROBIN(1'b1), .AU_LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dot_op_sequencer #(.ROUND_ROBIN(1'b0), .AU_LATENCY(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic int ent(input int err, input int id, input int res);
    return (err << 7) | (id << 6) | res;
  endfunction

  // Model: one pending op per instance, visible as a response from cycle 'due' until taken.
  bit         pend  [2];
  int         due   [2];
  bit         rr    [2];
  bit         m_id  [2];
  logic [5:0] m_res [2];
  bit         m_err [2];
  logic       m_op  [2];
  logic [2:0] m_a   [2];
  logic [2:0] m_b   [2];

  always @(posedge clk) begin
    bit         w;
    logic       o;
    logic [2:0] a, b;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        rr[k]   = 1'b0;
        m_op[k] = 1'b0;
        m_a[k]  = 3'd0;
        m_b[k]  = 3'd0;
      end else if (pend[k]) begin
        if (cyc >= due[k] && resp_ready) begin
          pend[k] = 1'b0;
          if (k == 0) rr[k] = ~m_id[k];
        end
      end else if (req_valid != 2'b00) begin
        w = (req_valid == 2'b11) ? rr[k] : req_valid[1];
        o = req_op[w];
        a = w ? req_op1[5:3] : req_op1[2:0];
        b = w ? req_op2[5:3] : req_op2[2:0];
        pend[k] = 1'b1;
        m_id[k] = w;
        m_op[k] = o;
        m_a[k]  = a;
        m_b[k]  = b;
        if (DZ && o && b == 3'd0) begin
          m_res[k] = 6'h3F;
          m_err[k] = 1'b1;
          due[k]   = cyc + 1;
        end else begin
          m_res[k] = au_ref(o, a, b);
          m_err[k] = 1'b0;
          due[k]   = cyc + 2 + lat_of(k);
        end
      end
    end
    cyc++;
  end

  // Delivered responses and measured latency, per instance.
  int dq0[$];
  int dq1[$];
  int acc_cyc  [2];
  int last_lat [2];
  bit prev_rv  [2];

  always @(negedge clk) begin
    logic [1:0] a_rdy;
    logic       a_rv, a_busy, a_op, a_id, a_err;
    logic [2:0] a_o1, a_o2;
    logic [5:0] a_res;
    bit         e_rv;
    for (int k = 0; k < 2; k++) begin
      a_rdy  = (k == 0) ? bus0.req_ready   : bus1.req_ready;
      a_rv   = (k == 0) ? bus0.resp_valid  : bus1.resp_valid;
      a_busy = (k == 0) ? bus0.busy        : bus1.busy;
      a_op   = (k == 0) ? bus0.au_op       : bus1.au_op;
      a_o1   = (k == 0) ? bus0.au_op1      : bus1.au_op1;
      a_o2   = (k == 0) ? bus0.au_op2      : bus1.au_op2;
      a_id   = (k == 0) ? bus0.resp_id     : bus1.resp_id;
      a_res  = (k == 0) ? bus0.resp_result : bus1.resp_result;
      a_err  = (k == 0) ? bus0.resp_err    : bus1.resp_err;
      e_rv   = pend[k] && cyc >= due[k];

      check($sformatf("dut%0d req_ready", k), int'(a_rdy),
            (rst || pend[k]) ? 0 : int'(exp_grant(req_valid, rr[k])));
      check($sformatf("dut%0d resp_valid", k), int'(a_rv), int'(e_rv));
      check($sformatf("dut%0d busy", k), int'(a_busy), int'(pend[k]));
      check($sformatf("dut%0d au_op", k), int'(a_op), int'(m_op[k]));
      check($sformatf("dut%0d au_op1", k), int'(a_o1), int'(m_a[k]));
      check($sformatf("dut%0d au_op2", k), int'(a_o2), int'(m_b[k]));
      if (e_rv) begin
        check($sformatf("dut%0d resp_id", k), int'(a_id), int'(m_id[k]));
        check($sformatf("dut%0d resp_result", k), int'(a_res), int'(m_res[k]));
        check($sformatf("dut%0d resp_err", k), int'(a_err), int'(m_err[k]));
      end

      if ((a_rdy & req_valid) != 2'b00) acc_cyc[k] = cyc;
      if (a_rv && !prev_rv[k]) last_lat[k] = cyc - acc_cyc[k];
      if (a_rv && resp_ready && !rst) begin
        if (k == 0) dq0.push_back(ent(int'(a_err), int'(a_id), int'(a_res)));
        else        dq1.push_back(ent(int'(a_err), int'(a_id), int'(a_res)));
      end
      prev_rv[k] = a_rv;
    end
  end

  function automatic int q_at(input int k, input int i);
    if (k == 0) return (i < dq0.size()) ? dq0[i] : -1;
    return (i < dq1.size()) ? dq1[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    dq0.delete();
    dq1.delete();
  endtask

  initial begin
    // Reset with both requesters asking; requester 0 carries 5*6.
    rst = 1'b1; req_valid = 2'b11; req_op = 2'b00;
    req_op1 = {3'd1, 3'd5}; req_op2 = {3'd1, 3'd6}; resp_ready = 1'b1;
    tick(); tick();
    check("reset req_ready", int'(bus0.req_ready), 0);
    check("reset resp_valid", int'(bus0.resp_valid), 0);
    check("reset busy", int'(bus1.busy), 0);
    check("reset au_op1", int'(bus0.au_op1), 0);
    check("reset resp_result", int'(bus1.resp_result), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset grant dut0", int'(bus0.req_ready), 1);
    check("post-reset grant dut1", int'(bus1.req_ready), 1);
    tick();
    req_valid = 2'b00;
    repeat (10) tick();
    check("mul count dut0", dq0.size(), 1);
    check("mul resp dut0", q_at(0, 0), ent(0, 0, 30));
    check("mul resp dut1", q_at(1, 0), ent(0, 0, 30));
    check("mul latency dut0", last_lat[0], 2);
    check("mul latency dut1", last_lat[1], 5);

    // Divide 7/2 from requester 1.
    clear_q();
    req_valid = 2'b10; req_op = 2'b10;
    req_op1 = {3'd7, 3'd0}; req_op2 = {3'd2, 3'd0};
    tick();
    req_valid = 2'b00;
    repeat (10) tick();
    check("div resp dut0", q_at(0, 0), ent(0, 1, 25));
    check("div resp dut1", q_at(1, 0), ent(0, 1, 25));
    check("div latency dut0", last_lat[0], 2);
    check("div latency dut1", last_lat[1], 5);

    // Contention: requester 0 does 3*5, requester 1 does 2*4.
    clear_q();
    req_valid = 2'b11; req_op = 2'b00;
    req_op1 = {3'd2, 3'd3}; req_op2 = {3'd4, 3'd5};
    repeat (24) tick();
    req_valid = 2'b00;
    repeat (10) tick();
    check("rr count dut0", dq0.size(), 8);
    check("rr resp0 dut0", q_at(0, 0), ent(0, 0, 15));
    check("rr resp1 dut0", q_at(0, 1), ent(0, 1, 8));
    check("rr resp2 dut0", q_at(0, 2), ent(0, 0, 15));
    check("rr resp3 dut0", q_at(0, 3), ent(0, 1, 8));
    check("fixed count dut1", dq1.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("fixed resp%0d dut1", i), q_at(1, i), ent(0, 0, 15));

    // Backpressure then reset: 3*3 must never be delivered.
    clear_q();
    resp_ready = 1'b0;
    req_valid = 2'b01; req_op = 2'b00;
    req_op1 = {3'd0, 3'd3}; req_op2 = {3'd0, 3'd3};
    tick();
    req_valid = 2'b11;
    repeat (8) tick();
    repeat (5) begin
      tick();
      check("hold resp_valid dut0", int'(bus0.resp_valid), 1);
      check("hold resp_result dut1", int'(bus1.resp_result), 9);
      check("hold req_ready dut1", int'(bus1.req_ready), 0);
      check("hold busy dut0", int'(bus0.busy), 1);
    end
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush resp_valid dut0", int'(bus0.resp_valid), 0);
    check("flush resp_valid dut1", int'(bus1.resp_valid), 0);
    resp_ready = 1'b1;
    repeat (10) tick();
    check("flush delivered dut0", dq0.size(), 0);
    check("flush delivered dut1", dq1.size(), 0);

    // Divide by zero: 4/0 from requester 0.
    clear_q();
    req_valid = 2'b01; req_op = 2'b01;
    req_op1 = {3'd0, 3'd4}; req_op2 = 6'd0;
    tick();
    req_valid = 2'b00;
    repeat (10) tick();
    check("divzero resp dut0", q_at(0, 0), DZ ? ent(1, 0, 63) : ent(0, 0, 0));
    check("divzero resp dut1", q_at(1, 0), DZ ? ent(1, 0, 63) : ent(0, 0, 0));
    check("divzero latency dut0", last_lat[0], DZ ? 1 : 2);
    check("divzero latency dut1", last_lat[1], DZ ? 1 : 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dot_op_sequencer.md
Name: dot_op_sequencer

Overview:
Sequencer and arbiter that time-shares one combinational 3-bit multiply/divide unit (the "AU") between two requesters. It accepts one operation at a time through valid/ready, drives the AU operand bus from registers, and captures the 6-bit result after a programmable settle time. It then returns the result through a valid/ready response channel tagged with the requester ID. It sits between the tile I/O decode logic and the shared AU instance.

Parameters:
ROUND_ROBIN, 1, 1 = alternate priority after each completed op; 0 = fixed priority, requester 0 always wins.
AU_LATENCY, 0, extra ISSUE cycles before result capture (0..7); covers a registered or slow AU.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  2  per-requester request valid; bit i = requester i
req_ready  output  2  one-hot grant/accept
req_op  input  2  per-requester opcode; 0 = multiply, 1 = divide
req_op1  input  6  operand 1; requester i in bits [3i+2:3i]
req_op2  input  6  operand 2; same packing
au_op  output  1  AU opcode
au_op1  output  3  AU operand 1
au_op2  output  3  AU operand 2
au_result  input  6  AU result: product[5:0], or {quotient[5:3], remainder[2:0]}
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_id  output  1  requester that issued the op
resp_result  output  6  captured result
resp_err  output  1  error flag; see Optional Feature
busy  output  1  high when state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, au_op/au_op1/au_op2=0, wait counter=0, busy=0.
- Reset mid-operation: the op in flight is discarded and produces no response. resp_valid is low from the first cycle after the reset edge.
- States: IDLE, ISSUE, RESP.
- IDLE, req_ready:
  - Combinational; nonzero only in IDLE.
  - Exactly one valid requester: that requester is granted.
  - Both valid: rr_ptr selects the winner.
  - No valid requester: req_ready=00.
- IDLE, accept (req_valid[i] & req_ready[i]):
  - Register the op, operands and id into au_op/au_op1/au_op2 and the id latch.
  - Load the wait counter with AU_LATENCY; go to ISSUE.
  - Dropping valid before a grant carries no commitment.
- ISSUE:
  - au_* hold the registered values; they change only on accept or reset.
  - Counter != 0: decrement and stay.
  - Counter == 0: resp_result<=au_result, resp_id<=id, resp_valid<=1, go to RESP.
- RESP:
  - resp_* held stable while resp_ready=0.
  - On resp_valid & resp_ready: resp_valid<=0, go to IDLE.
  - If ROUND_ROBIN=1, rr_ptr<=~resp_id; otherwise rr_ptr stays 0.
- Latency and throughput:
  - Accept in cycle N; resp_valid high in cycle N+2+AU_LATENCY.
  - Peak throughput with resp_ready tied high: one op per 3+AU_LATENCY cycles.
- No new request is accepted while busy; no queuing, no wrap-around state.
- resp_result is passed through unmodified (no width extension). resp_err=0 unless the optional feature sets it.

Optional Feature:
Macro DOT_SEQ_DIVZERO_EN.
- Defined: an accepted op with op=1 and op2=000 skips ISSUE. It goes to RESP the next cycle with resp_result=6'h3F and resp_err=1. The AU is not consulted, but au_* are still updated.
- Undefined: divide-by-zero follows the normal path. resp_result is the AU output (000000 for the standard AU) and resp_err is constant 0.

Test Plan:
1. Reset: assert rst for 2 cycles with req_valid=11 -> req_ready=00 during reset; resp_valid=0; busy=0; au_*=0. req_ready=01 the cycle after release.
2. Multiply, requester 0: op=0, op1=5, op2=6, AU model attached, resp_ready=1 -> resp_valid 2 cycles after accept; resp_result=011110 (30); resp_id=0; resp_err=0.
3. Divide, requester 1, AU_LATENCY=3: op=1, op1=7, op2=2 -> resp_valid 5 cycles after accept; resp_result=011001 (q=3, r=1); resp_id=1.
4. Contention: both valid continuously, resp_ready=1 -> ROUND_ROBIN=1 gives resp_id sequence 0,1,0,1; ROUND_ROBIN=0 gives 0,0,0,0.
5. Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=00, busy=1. Then pulse rst -> resp_valid=0 next cycle, and no response is ever delivered for that op.
6. Divide by zero: op=1, op1=4, op2=0 -> with DOT_SEQ_DIVZERO_EN, resp_result=111111 and resp_err=1 one cycle after accept. Without the macro, resp_result=000000 and resp_err=0 after normal latency.
